// File: rtl/vlane_flagalu_seq_if.sv
// Instruction handshake plus flag register file read/write bus of the flag-logic sequencer.
// Modport master faces the sequencer: it offers instructions and returns read data.
interface vlane_flagalu_seq_if #(
    parameter int NUMLANES     = 4,
    parameter int LOG2MVL      = 6,
    parameter int LOG2NUMFREGS = 3
);
    logic                    in_valid;
    logic                    in_ready;
    logic [2:0]              in_op;
    logic [LOG2MVL:0]        in_vl;
    logic [LOG2NUMFREGS-1:0] in_src1;
    logic [LOG2NUMFREGS-1:0] in_src2;
    logic [LOG2NUMFREGS-1:0] in_dst;
    logic                    rd_en;
    logic [LOG2NUMFREGS-1:0] rd_reg1;
    logic [LOG2NUMFREGS-1:0] rd_reg2;
    logic [LOG2MVL-1:0]      rd_elm;
    logic [NUMLANES-1:0]     rd_data1;
    logic [NUMLANES-1:0]     rd_data2;
    logic                    wr_en;
    logic [LOG2NUMFREGS-1:0] wr_reg;
    logic [LOG2MVL-1:0]      wr_elm;
    logic [NUMLANES-1:0]     wr_mask;
    logic [NUMLANES-1:0]     wr_data;
    logic                    busy;
    logic                    done;

    modport slave (
        input  in_valid, in_op, in_vl, in_src1, in_src2, in_dst, rd_data1, rd_data2,
        output in_ready, rd_en, rd_reg1, rd_reg2, rd_elm,
               wr_en, wr_reg, wr_elm, wr_mask, wr_data, busy, done
    );

    modport master (
        output in_valid, in_op, in_vl, in_src1, in_src2, in_dst, rd_data1, rd_data2,
        input  in_ready, rd_en, rd_reg1, rd_reg2, rd_elm,
               wr_en, wr_reg, wr_elm, wr_mask, wr_data, busy, done
    );
endinterface

// File: rtl/vlane_flagalu_seq.sv
// Vector flag-logic sequencer: walks the flag register file one NUMLANES-wide group per
// cycle, combining two source groups and writing the masked result one cycle later.
module vlane_flagalu_lane (
    input  logic [2:0] op,
    input  logic       a,
    input  logic       b,
    output logic       y
);
    always_comb begin
        case (op)
            3'd0:    y = a & b;
            3'd1:    y = a | b;
            3'd2:    y = a ^ b;
            3'd3:    y = ~(a | b);
            3'd5:    y = 1'b1;
            default: y = 1'b0;
        endcase
    end
endmodule

module vlane_flagalu_seq #(
    parameter int NUMLANES     = 4,
    parameter int LOG2NUMLANES = 2,
    parameter int MVL          = 64,
    parameter int LOG2MVL      = 6,
    parameter int LOG2NUMFREGS = 3
) (
    input  logic                clk,
    input  logic                resetn,
    vlane_flagalu_seq_if.slave  bus
);
    localparam int CW = LOG2MVL - LOG2NUMLANES + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    typedef struct packed {
        logic [2:0]              op;
        logic [LOG2NUMFREGS-1:0] src1;
        logic [LOG2NUMFREGS-1:0] src2;
        logic [LOG2NUMFREGS-1:0] dst;
    } instr_t;

    state_t                state, state_nx;
    instr_t                ins;
    logic [LOG2MVL:0]      vl_q;
    logic [LOG2MVL:0]      vl_clamp;
    logic [CW-1:0]         grp, ngrp, ngrp_in;
    logic                  accept;
    logic                  rd_vld, wr_vld;
    logic [LOG2MVL-1:0]    rd_elm_c, wr_elm_q;
    logic [NUMLANES-1:0]   mask_c, wr_mask_q, lane_y;

    assign accept   = bus.in_valid && (state == IDLE);
    assign vl_clamp = (bus.in_vl > (LOG2MVL+1)'(MVL)) ? (LOG2MVL+1)'(MVL) : bus.in_vl;
    // Clamped length plus NUMLANES-1 still fits LOG2MVL+1 bits, so the ceil cannot overflow.
    assign ngrp_in  = CW'((vl_clamp + (LOG2MVL+1)'(NUMLANES-1)) >> LOG2NUMLANES);
    assign rd_vld   = (state == READ);
    assign rd_elm_c = {grp[CW-2:0], LOG2NUMLANES'(0)};

    for (genvar i = 0; i < NUMLANES; i++) begin : g_lane
        // Element index {grp,i} is exactly LOG2MVL+1 bits, matching vl_q.
        assign mask_c[i] = ({grp, LOG2NUMLANES'(i)} < vl_q);
        vlane_flagalu_lane u_lane (
            .op (ins.op),
            .a  (bus.rd_data1[i]),
            .b  (bus.rd_data2[i]),
            .y  (lane_y[i])
        );
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = (vl_clamp == '0) ? DRAIN : READ;
            READ:    if (grp == ngrp - CW'(1)) state_nx = DRAIN;
            DRAIN:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            ins       <= '0;
            vl_q      <= '0;
            grp       <= '0;
            ngrp      <= '0;
            wr_vld    <= 1'b0;
            wr_elm_q  <= '0;
            wr_mask_q <= '0;
        end else begin
            state  <= state_nx;
            wr_vld <= rd_vld;
            if (accept) begin
                ins  <= '{op: bus.in_op, src1: bus.in_src1, src2: bus.in_src2, dst: bus.in_dst};
                vl_q <= vl_clamp;
                ngrp <= ngrp_in;
                grp  <= '0;
            end else if (rd_vld) begin
                grp <= grp + CW'(1);
            end
            if (rd_vld) begin
                wr_elm_q  <= rd_elm_c;
                wr_mask_q <= mask_c;
            end
        end
    end

    assign bus.in_ready = (state == IDLE);
    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DRAIN);
    assign bus.rd_en    = rd_vld;
    assign bus.rd_reg1  = rd_vld ? ins.src1 : '0;
    assign bus.rd_reg2  = rd_vld ? ins.src2 : '0;
    assign bus.rd_elm   = rd_vld ? rd_elm_c : '0;
    // Read data lands in the write cycle, so the op is applied combinationally there.
    assign bus.wr_en    = wr_vld;
    assign bus.wr_reg   = wr_vld ? ins.dst : '0;
    assign bus.wr_elm   = wr_vld ? wr_elm_q : '0;
    assign bus.wr_mask  = wr_vld ? wr_mask_q : '0;
    assign bus.wr_data  = wr_vld ? lane_y : '0;
endmodule

// File: tb/tb_vlane_flagalu_seq.sv
// Scoreboard bench for vlane_flagalu_seq: stimulus queues expected reads, writes and
// done pulses; a negedge monitor pops and compares whatever the DUT presents.
module tb_vlane_flagalu_seq;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    vlane_flagalu_seq_if #(.NUMLANES(4), .LOG2MVL(6), .LOG2NUMFREGS(3)) bus ();

    vlane_flagalu_seq #(
        .NUMLANES(4), .LOG2NUMLANES(2), .MVL(64), .LOG2MVL(6), .LOG2NUMFREGS(3)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        int         cyc;
        logic [2:0] r1;
        logic [2:0] r2;
        logic [5:0] elm;
        logic [3:0] mask;
        logic [3:0] data;
    } ev_t;

    ev_t  rq[$];
    ev_t  wq[$];
    int   dq[$];
    int   cyc = 0;
    int   ntest = 0;
    int   nfail = 0;
    logic [3:0] fr1 [16];
    logic [3:0] fr2 [16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        ntest++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [3:0] mask_of(input int vle, input int g);
        int rem;
        rem = vle - g * 4;
        if (rem >= 4) return 4'hF;
        return 4'((1 << rem) - 1);
    endfunction

    // Queue the expected bus events of one instruction offered in cycle t, up to cycle cut.
    task automatic push_exp(input int t, input int vl, input logic [2:0] s1, input logic [2:0] s2,
                            input logic [2:0] d, input logic [3:0] ea, input logic [3:0] eb,
                            input int cut, output int ng);
        int  vle;
        ev_t e;
        vle = (vl > 64) ? 64 : vl;
        ng  = (vle + 3) / 4;
        for (int g = 0; g < ng; g++) begin
            e.cyc = t + 1 + g; e.r1 = s1; e.r2 = s2; e.elm = 6'(g * 4); e.mask = '0; e.data = '0;
            if (e.cyc <= cut) rq.push_back(e);
            e.cyc = t + 2 + g; e.r1 = d; e.r2 = '0; e.mask = mask_of(vle, g);
            e.data = (g == 0) ? ea : eb;
            if (e.cyc <= cut) wq.push_back(e);
        end
        if (t + ng + 1 <= cut) dq.push_back(t + ng + 1);
    endtask

    task automatic drive(input logic [2:0] op, input int vl, input logic [2:0] s1,
                         input logic [2:0] s2, input logic [2:0] d,
                         input logic [3:0] d1a, input logic [3:0] d2a,
                         input logic [3:0] d1b, input logic [3:0] d2b);
        fr1[0] = d1a; fr2[0] = d2a;
        for (int k = 1; k < 16; k++) begin fr1[k] = d1b; fr2[k] = d2b; end
        bus.in_op = op; bus.in_vl = 7'(vl);
        bus.in_src1 = s1; bus.in_src2 = s2; bus.in_dst = d;
        bus.in_valid = 1'b1;
    endtask

    task automatic issue(input logic [2:0] op, input int vl, input logic [2:0] s1,
                         input logic [2:0] s2, input logic [2:0] d,
                         input logic [3:0] d1a, input logic [3:0] d2a, input logic [3:0] ea,
                         input logic [3:0] d1b, input logic [3:0] d2b, input logic [3:0] eb,
                         input int cut_rel, output int t, output int ng);
        @(negedge clk);
        check("in_ready_idle", 64'(bus.in_ready), 64'd1);
        t = cyc;
        drive(op, vl, s1, s2, d, d1a, d2a, d1b, d2b);
        push_exp(t, vl, s1, s2, d, ea, eb, (cut_rel < 0) ? 1000000 : t + cut_rel, ng);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("busy_after_accept", 64'({bus.busy, bus.in_ready}), 64'b10);
    endtask

    task automatic finish_op(input int t, input int ng);
        while (cyc < t + ng + 2) @(negedge clk);
        check("ready_after_done", 64'({bus.in_ready, bus.busy}), 64'b10);
    endtask

    // Flag register file model: returns the addressed group the cycle after rd_en.
    always begin
        logic       ren;
        logic [3:0] ridx;
        @(negedge clk);
        ren  = bus.rd_en;
        ridx = bus.rd_elm[5:2];
        @(posedge clk);
        #1;
        bus.rd_data1 = ren ? fr1[ridx] : 4'h0;
        bus.rd_data2 = ren ? fr2[ridx] : 4'h0;
    end

    always @(negedge clk) begin
        ev_t e;
        while (rq.size() > 0 && rq[0].cyc < cyc) begin
            e = rq.pop_front(); check("rd_missing", 64'(cyc), 64'(e.cyc));
        end
        while (wq.size() > 0 && wq[0].cyc < cyc) begin
            e = wq.pop_front(); check("wr_missing", 64'(cyc), 64'(e.cyc));
        end
        while (dq.size() > 0 && dq[0] < cyc) begin
            check("done_missing", 64'(cyc), 64'(dq.pop_front()));
        end
        if (bus.rd_en) begin
            if (rq.size() == 0) check("rd_unexpected", 64'(bus.rd_elm), 64'hFFFF);
            else begin
                e = rq.pop_front();
                check("rd_cyc_reg_elm", {32'(cyc), 17'd0, bus.rd_reg1, bus.rd_reg2, bus.rd_elm},
                      {32'(e.cyc), 17'd0, e.r1, e.r2, e.elm});
            end
        end
        if (bus.wr_en) begin
            if (wq.size() == 0) check("wr_unexpected", 64'(bus.wr_elm), 64'hFFFF);
            else begin
                e = wq.pop_front();
                check("wr_cyc_reg_elm_mask_data",
                      {32'(cyc), 15'd0, bus.wr_reg, bus.wr_elm, bus.wr_mask, bus.wr_data},
                      {32'(e.cyc), 15'd0, e.r1, e.elm, e.mask, e.data});
            end
        end
        if (bus.done) begin
            if (dq.size() == 0) check("done_unexpected", 64'(cyc), 64'hFFFF);
            else check("done_cyc", 64'(cyc), 64'(dq.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1);
    end

    initial begin
        int t, ng, t2;
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_vl = '0;
        bus.in_src1 = '0; bus.in_src2 = '0; bus.in_dst = '0;
        bus.rd_data1 = '0; bus.rd_data2 = '0;
        for (int k = 0; k < 16; k++) begin fr1[k] = '0; fr2[k] = '0; end

        repeat (3) @(negedge clk);
        check("reset_strobes", 64'({bus.rd_en, bus.wr_en, bus.busy, bus.done, bus.in_ready}), 64'b00001);
        check("reset_addr_data", 64'({bus.rd_reg1, bus.rd_reg2, bus.rd_elm, bus.wr_reg,
                                      bus.wr_elm, bus.wr_mask, bus.wr_data}), 64'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(bus.in_ready), 64'd1);

        // AND vl=8: 1010&1100 = 1000 in both groups
        issue(3'd0, 8, 3'd1, 3'd2, 3'd3, 4'b1010, 4'b1100, 4'b1000, 4'b1010, 4'b1100, 4'b1000, -1, t, ng);
        finish_op(t, ng);
        // OR vl=6: partial second group, mask 0011
        issue(3'd1, 6, 3'd4, 3'd5, 3'd6, 4'b0101, 4'b0011, 4'b0111, 4'b0001, 4'b0010, 4'b0011, -1, t, ng);
        finish_op(t, ng);
        // SET vl=0: done only, no traffic
        issue(3'd5, 0, 3'd0, 3'd1, 3'd2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, -1, t, ng);
        finish_op(t, ng);
        // NOR, op 7 (as CLR), XOR, CLR on 0101|0011
        issue(3'd3, 4, 3'd1, 3'd2, 3'd3, 4'b0101, 4'b0011, 4'b1000, 4'h0, 4'h0, 4'h0, -1, t, ng);
        finish_op(t, ng);
        issue(3'd7, 4, 3'd1, 3'd2, 3'd3, 4'b0101, 4'b0011, 4'b0000, 4'h0, 4'h0, 4'h0, -1, t, ng);
        finish_op(t, ng);
        issue(3'd2, 4, 3'd7, 3'd6, 3'd5, 4'b0101, 4'b0011, 4'b0110, 4'h0, 4'h0, 4'h0, -1, t, ng);
        finish_op(t, ng);
        issue(3'd4, 4, 3'd1, 3'd2, 3'd3, 4'b1111, 4'b1111, 4'b0000, 4'h0, 4'h0, 4'h0, -1, t, ng);
        finish_op(t, ng);
        // SET vl=5: second group mask 0001
        issue(3'd5, 5, 3'd1, 3'd2, 3'd3, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b1111, -1, t, ng);
        finish_op(t, ng);
        // vl=70 clamps to 64: 16 groups, XOR 0110^0101 = 0011
        issue(3'd2, 70, 3'd2, 3'd3, 3'd4, 4'b0110, 4'b0101, 4'b0011, 4'b0110, 4'b0101, 4'b0011, -1, t, ng);
        check("clamp_groups", 64'(ng), 64'd16);
        finish_op(t, ng);

        // in_valid held: second accept lands at T+4
        @(negedge clk);
        check("in_ready_idle", 64'(bus.in_ready), 64'd1);
        t = cyc;
        drive(3'd0, 8, 3'd1, 3'd2, 3'd3, 4'b1010, 4'b1100, 4'b1010, 4'b1100);
        push_exp(t, 8, 3'd1, 3'd2, 3'd3, 4'b1000, 4'b1000, 1000000, ng);
        push_exp(t + 4, 8, 3'd1, 3'd2, 3'd3, 4'b1000, 4'b1000, 1000000, ng);
        while (cyc < t + 4) @(negedge clk);
        check("second_accept_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        finish_op(t + 4, ng);

        // Reset at T+2 during vl=16: only read/write traffic up to T+2 survives
        issue(3'd1, 16, 3'd1, 3'd2, 3'd3, 4'b0101, 4'b0011, 4'b0111, 4'b0101, 4'b0011, 4'b0111, 2, t2, ng);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("abort_strobes", 64'({bus.rd_en, bus.wr_en, bus.done, bus.busy, bus.in_ready}), 64'b00001);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("abort_quiet", 64'({bus.rd_en, bus.wr_en, bus.done, bus.busy, bus.in_ready}), 64'b00001);

        // Fresh instruction with dst == src1: 1111^1010 = 0101
        issue(3'd2, 8, 3'd2, 3'd5, 3'd2, 4'b1111, 4'b1010, 4'b0101, 4'b1111, 4'b1010, 4'b0101, -1, t, ng);
        finish_op(t, ng);

        repeat (3) @(negedge clk);
        check("rd_queue_empty", 64'(rq.size()), 64'd0);
        check("wr_queue_empty", 64'(wq.size()), 64'd0);
        check("done_queue_empty", 64'(dq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end
endmodule
